// File: rtl/clk_div_if.sv
// Bus bundle for clk_div_multi: per-channel enables, half-period write port and divided outputs.
// The tick vector exists only when CLKDIV_TICK_EN is defined.
interface clk_div_if #(
  parameter int NCH = 4,
  parameter int CW  = 26
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] en;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_half;
  logic           wr_ack;
  logic [NCH-1:0] clk_out;
`ifdef CLKDIV_TICK_EN
  logic [NCH-1:0] tick;
`endif

  modport master (
    output en, wr_en, wr_ch, wr_half,
`ifdef CLKDIV_TICK_EN
    input  tick,
`endif
    input  wr_ack, clk_out
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_half,
`ifdef CLKDIV_TICK_EN
    output tick,
`endif
    output wr_ack, clk_out
  );
endinterface

// File: rtl/clk_div_multi.sv
// NCH-channel programmable 50%-duty clock divider with runtime-loadable half-periods.
// Optional per-toggle tick pulses are built only when CLKDIV_TICK_EN is defined.
module clk_div_multi #(
  parameter int NCH      = 4,
  parameter int CW       = 26,
  parameter int DEF_HALF = 16666666
) (
  input  logic      clk,
  input  logic      rst,
  clk_div_if.slave  bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] DEF_HALF_W = CW'(DEF_HALF);

  logic [CW-1:0]  cnt  [NCH];
  logic [CW-1:0]  half [NCH];
  logic [NCH-1:0] clk_q;
  logic           ack_q;
  logic [NCH-1:0] wr_hit;
  logic [NCH-1:0] term;
  logic [CW-1:0]  wr_half_c;

  // A zero half-period would never reach terminal count, so it is treated as 1.
  assign wr_half_c = (bus.wr_half == '0) ? CW'(1) : bus.wr_half;

  // Out-of-range channel numbers match no channel, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = bus.wr_en && (bus.wr_ch == CHW'(i));
      term[i]   = bus.en[i] && (cnt[i] == half[i] - CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      clk_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]  <= '0;
        half[i] <= DEF_HALF_W;
      end
    end else begin
      ack_q <= bus.wr_en;
      for (int i = 0; i < NCH; i++) begin
        // A write restarts the count and suppresses a coincident toggle.
        if (wr_hit[i]) begin
          half[i] <= wr_half_c;
          cnt[i]  <= '0;
        end else if (term[i]) begin
          cnt[i]   <= '0;
          clk_q[i] <= ~clk_q[i];
        end else if (bus.en[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign bus.wr_ack  = ack_q;
  assign bus.clk_out = clk_q;

`ifdef CLKDIV_TICK_EN
  logic [NCH-1:0] tick_q;

  always_ff @(posedge clk) begin
    if (rst) tick_q <= '0;
    else     tick_q <= term & ~wr_hit;
  end

  assign bus.tick = tick_q;
`endif

endmodule
